// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball game sequencer.
// Holds state codes, screen geometry, velocity width and motion helpers.
package pinball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_PLAY   = 3'd2,
        ST_LOST   = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam int VW         = 6;
    localparam int BORDER_XL  = 160;
    localparam int BORDER_XR  = 644;
    localparam int BORDER_TOP = 52;
    localparam int LOST_Y_DEF = 500;

    function automatic logic signed [VW-1:0] vabs(
        input logic signed [VW-1:0] v
    );
        return v[VW-1] ? -v : v;
    endfunction

    // Position step: negative results stick at 0, overflow sticks at 1023.
    function automatic logic [9:0] pos_step(
        input logic [9:0]           p,
        input logic signed [VW-1:0] v
    );
        logic [11:0] s;
        s = {2'b00, p} + {{(12-VW){v[VW-1]}}, v};
        if (s[11]) return 10'd0;
        if (s[10]) return 10'h3FF;
        return s[9:0];
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, saturating at 99, with synchronous clear.
// Ports: i_clk, i_rst_n, i_clr, i_en in; o_bcd (8-bit BCD) out.
module bcd_counter2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [7:0] o_bcd
);
    logic [3:0] r_lo;
    logic [3:0] r_hi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo <= 4'd0;
            r_hi <= 4'd0;
        end else if (i_clr) begin
            r_lo <= 4'd0;
            r_hi <= 4'd0;
        end else if (i_en && !(r_hi == 4'd9 && r_lo == 4'd9)) begin
            if (r_lo == 4'd9) begin
                r_lo <= 4'd0;
                r_hi <= r_hi + 4'd1;
            end else begin
                r_lo <= r_lo + 4'd1;
            end
        end
    end

    assign o_bcd = {r_hi, r_lo};
endmodule

// File: rtl/pinball_game_ctrl.sv
// Per-frame pinball game sequencer: ball motion, flippers, score, lives, timer.
// In: clk, rst_n, frame_tick, buttons, collision flags. Out: ball, flippers, BCD fields, lives, state.
module pinball_game_ctrl
    import pinball_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BALL_X0     = 180,
    parameter int BALL_Y0     = 242,
    parameter int VX0         = 5,
    parameter int VY0         = -1,
    parameter int VMAX        = 8,
    parameter int GRAV_DIV    = 4,
    parameter int VKICK       = 7,
    parameter int FLIP_MAX    = 40,
    parameter int FLIP_STEP   = 4,
    parameter int LOST_Y      = LOST_Y_DEF,
    parameter int LIVES0      = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       startbutton,
    input  logic       start_sagkol,
    input  logic       start_solkol,
    input  logic       hit_wall_l,
    input  logic       hit_wall_r,
    input  logic       hit_top,
    input  logic [3:0] hit_bumper,
    input  logic       hit_flip_l,
    input  logic       hit_flip_r,
    output logic [9:0] X_top_merkez,
    output logic [9:0] Y_top_merkez,
    output logic [5:0] doga_sag,
    output logic [5:0] doga_sol,
    output logic [7:0] score_bcd,
    output logic [7:0] time_bcd,
    output logic [1:0] lives,
    output logic [2:0] state
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [9:0]           LP_X0    = 10'(BALL_X0);
    localparam logic [9:0]           LP_Y0    = 10'(BALL_Y0);
    localparam logic [9:0]           LP_LOSTY = 10'(LOST_Y);
    localparam logic signed [VW-1:0] LP_VX0   = VW'(VX0);
    localparam logic signed [VW-1:0] LP_VY0   = VW'(VY0);
    localparam logic signed [VW-1:0] LP_VMAX  = VW'(VMAX);
    localparam logic signed [VW-1:0] LP_KICK  = VW'(VKICK);
    localparam logic [5:0]           LP_FMAX  = 6'(FLIP_MAX);
    localparam logic [5:0]           LP_FSTEP = 6'(FLIP_STEP);
    localparam logic [7:0]           LP_GLAST = 8'(GRAV_DIV - 1);
    localparam logic [7:0]           LP_LLAST = 8'(LOST_FRAMES - 1);
    localparam logic [1:0]           LP_LIV0  = 2'(LIVES0);
    localparam logic [CW-1:0]        LP_SLAST = CW'(CLK_HZ - 1);

    function automatic logic [5:0] flip_next(
        input logic [5:0] a,
        input logic       held
    );
        if (held)
            return (a >= LP_FMAX - LP_FSTEP) ? LP_FMAX : a + LP_FSTEP;
        return (a <= LP_FSTEP) ? 6'd0 : a - LP_FSTEP;
    endfunction

    logic [1:0] r_rst_ff;
    logic       w_rst_n;

    // Reset asserts immediately, releases two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_ff <= 2'b00;
        else        r_rst_ff <= {r_rst_ff[0], 1'b1};
    end
    assign w_rst_n = r_rst_ff[1];

    logic [2:0] r_start_s;
    logic [1:0] r_sag_s;
    logic [1:0] r_sol_s;
    logic       w_start_pulse;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_start_s <= 3'b000;
            r_sag_s   <= 2'b11;
            r_sol_s   <= 2'b11;
        end else begin
            r_start_s <= {r_start_s[1:0], startbutton};
            r_sag_s   <= {r_sag_s[0], start_sagkol};
            r_sol_s   <= {r_sol_s[0], start_solkol};
        end
    end
    assign w_start_pulse = r_start_s[1] & ~r_start_s[2];

    state_e                 r_state;
    state_e                 w_next;
    logic [9:0]             r_x;
    logic [9:0]             r_y;
    logic signed [VW-1:0]   r_vx;
    logic signed [VW-1:0]   r_vy;
    logic [5:0]             r_sag;
    logic [5:0]             r_sol;
    logic [1:0]             r_lives;
    logic [7:0]             r_grav_cnt;
    logic [7:0]             r_lost_cnt;
    logic [CW-1:0]          r_sec_cnt;

    logic signed [VW-1:0]   w_vx_c;
    logic signed [VW-1:0]   w_vy_c;
    logic signed [VW-1:0]   w_vy_g;
    logic                   w_bump;
    logic                   w_kick;
    logic                   w_grav;
    logic                   w_sec_tc;
    logic [9:0]             w_x_new;
    logic [9:0]             w_y_new;
    logic                   w_play_tick;

    assign w_play_tick = (r_state == ST_PLAY) && frame_tick;
    assign w_grav      = (r_grav_cnt == LP_GLAST);
    assign w_sec_tc    = (r_sec_cnt == LP_SLAST);
    assign w_kick      = (hit_flip_l && r_sol != 6'd0) ||
                         (hit_flip_r && r_sag != 6'd0);

    // One collision rule per frame, highest priority first.
    always_comb begin
        w_vx_c = r_vx;
        w_vy_c = r_vy;
        w_bump = 1'b0;
        if (hit_wall_l) begin
            w_vx_c = vabs(r_vx);
        end else if (hit_wall_r) begin
            w_vx_c = -vabs(r_vx);
        end else if (hit_top) begin
            w_vy_c = vabs(r_vy);
        end else if (|hit_bumper) begin
            w_vx_c = -r_vx;
            w_vy_c = -r_vy;
            w_bump = 1'b1;
        end else if (w_kick) begin
            w_vy_c = -LP_KICK;
        end
        w_vy_g = w_vy_c;
        if (w_grav) w_vy_g = w_vy_c + 6'sd1;
        if (w_vy_g > LP_VMAX)       w_vy_g = LP_VMAX;
        else if (w_vy_g < -LP_VMAX) w_vy_g = -LP_VMAX;
    end

    assign w_x_new = pos_step(r_x, w_vx_c);
    assign w_y_new = pos_step(r_y, w_vy_g);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start_pulse) w_next = ST_LAUNCH;
            ST_LAUNCH: if (w_start_pulse) w_next = ST_PLAY;
            ST_PLAY:   if (frame_tick && w_y_new >= LP_LOSTY) w_next = ST_LOST;
            ST_LOST:
                if (frame_tick && r_lost_cnt == LP_LLAST)
                    w_next = (r_lives == 2'd0) ? ST_OVER : ST_LAUNCH;
            ST_OVER:   if (w_start_pulse) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_x        <= LP_X0;
            r_y        <= LP_Y0;
            r_vx       <= LP_VX0;
            r_vy       <= LP_VY0;
            r_grav_cnt <= 8'd0;
        end else if (r_state == ST_IDLE || r_state == ST_LAUNCH) begin
            r_x        <= LP_X0;
            r_y        <= LP_Y0;
            r_vx       <= LP_VX0;
            r_vy       <= LP_VY0;
            r_grav_cnt <= 8'd0;
        end else if (w_play_tick) begin
            r_x        <= w_x_new;
            r_y        <= w_y_new;
            r_vx       <= w_vx_c;
            r_vy       <= w_vy_g;
            r_grav_cnt <= w_grav ? 8'd0 : r_grav_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sag <= 6'd0;
            r_sol <= 6'd0;
        end else if (r_state != ST_PLAY) begin
            r_sag <= 6'd0;
            r_sol <= 6'd0;
        end else if (frame_tick) begin
            r_sag <= flip_next(r_sag, ~r_sag_s[1]);
            r_sol <= flip_next(r_sol, ~r_sol_s[1]);
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lives    <= LP_LIV0;
            r_lost_cnt <= 8'd0;
        end else begin
            if (r_state == ST_IDLE)
                r_lives <= LP_LIV0;
            else if (r_state == ST_PLAY && w_next == ST_LOST)
                r_lives <= r_lives - 2'd1;
            if (r_state != ST_LOST)
                r_lost_cnt <= 8'd0;
            else if (frame_tick)
                r_lost_cnt <= r_lost_cnt + 8'd1;
        end
    end

    // Seconds prescaler only advances in play and keeps its phase otherwise.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                r_sec_cnt <= '0;
        else if (r_state == ST_PLAY) r_sec_cnt <= w_sec_tc ? '0 : r_sec_cnt + 1'b1;
    end

    bcd_counter2 u_score (
        .i_clk   (clk),
        .i_rst_n (w_rst_n),
        .i_clr   (r_state == ST_IDLE),
        .i_en    (w_play_tick && w_bump),
        .o_bcd   (score_bcd)
    );

    bcd_counter2 u_time (
        .i_clk   (clk),
        .i_rst_n (w_rst_n),
        .i_clr   (r_state == ST_IDLE),
        .i_en    ((r_state == ST_PLAY) && w_sec_tc),
        .o_bcd   (time_bcd)
    );

    assign X_top_merkez = r_x;
    assign Y_top_merkez = r_y;
    assign doga_sag     = r_sag;
    assign doga_sol     = r_sol;
    assign lives        = r_lives;
    assign state        = r_state;
endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl with a short 50-cycle second.
// Each scenario task drives stimulus and checks against hand-computed values.
module tb_pinball_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       startbutton = 1'b0;
    logic       start_sagkol = 1'b1;
    logic       start_solkol = 1'b1;
    logic       hit_wall_l = 1'b0;
    logic       hit_wall_r = 1'b0;
    logic       hit_top = 1'b0;
    logic [3:0] hit_bumper = 4'd0;
    logic       hit_flip_l = 1'b0;
    logic       hit_flip_r = 1'b0;
    logic [9:0] X_top_merkez;
    logic [9:0] Y_top_merkez;
    logic [5:0] doga_sag;
    logic [5:0] doga_sol;
    logic [7:0] score_bcd;
    logic [7:0] time_bcd;
    logic [1:0] lives;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    pinball_game_ctrl #(.CLK_HZ(50)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .startbutton  (startbutton),
        .start_sagkol (start_sagkol),
        .start_solkol (start_solkol),
        .hit_wall_l   (hit_wall_l),
        .hit_wall_r   (hit_wall_r),
        .hit_top      (hit_top),
        .hit_bumper   (hit_bumper),
        .hit_flip_l   (hit_flip_l),
        .hit_flip_r   (hit_flip_r),
        .X_top_merkez (X_top_merkez),
        .Y_top_merkez (Y_top_merkez),
        .doga_sag     (doga_sag),
        .doga_sol     (doga_sol),
        .score_bcd    (score_bcd),
        .time_bcd     (time_bcd),
        .lives        (lives),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start;
        @(negedge clk) startbutton = 1'b1;
        repeat (4) @(negedge clk);
        startbutton = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic wl, input logic wr, input logic tp,
                         input logic [3:0] bm, input logic fl, input logic fr);
        @(negedge clk);
        hit_wall_l = wl; hit_wall_r = wr; hit_top = tp;
        hit_bumper = bm; hit_flip_l = fl; hit_flip_r = fr;
        frame_tick = 1'b1;
        @(negedge clk);
        hit_wall_l = 0; hit_wall_r = 0; hit_top = 0;
        hit_bumper = 0; hit_flip_l = 0; hit_flip_r = 0;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_ball(input string nm, input int ex, input int ey);
        n_cmp++;
        if (X_top_merkez !== 10'(ex) || Y_top_merkez !== 10'(ey)) begin
            n_bad++;
            $display("FAIL %s: ball got (%0d,%0d) want (%0d,%0d)",
                     nm, X_top_merkez, Y_top_merkez, ex, ey);
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (state !== 3'd0 || lives !== 2'd3 || score_bcd !== 8'h00 ||
            time_bcd !== 8'h00 || doga_sag !== 6'd0 || doga_sol !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_regs: st=%0d lv=%0d sc=%h tm=%h sag=%0d sol=%0d want 0 3 00 00 0 0",
                     state, lives, score_bcd, time_bcd, doga_sag, doga_sol);
        end
        check_ball("reset_ball", 180, 242);
    endtask

    task automatic test_motion;
        int ex[4] = '{185, 190, 195, 200};
        int ey[4] = '{241, 240, 239, 239};
        do_reset();
        pulse_start();
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++; $display("FAIL launch_state: got %0d want 1", state);
        end
        pulse_start();
        n_cmp++;
        if (state !== 3'd2) begin
            n_bad++; $display("FAIL play_state: got %0d want 2", state);
        end
        check_ball("launch_hold", 180, 242);
        for (int i = 0; i < 4; i++) begin
            frame(0, 0, 0, 4'd0, 0, 0);
            check_ball($sformatf("motion_t%0d", i + 1), ex[i], ey[i]);
        end
    endtask

    task automatic test_priority;
        do_reset();
        pulse_start();
        pulse_start();
        frame(0, 1, 0, 4'b0011, 0, 0);
        check_ball("wall_r_over_bumper", 175, 241);
        n_cmp++;
        if (score_bcd !== 8'h00) begin
            n_bad++; $display("FAIL wall_prio_score: got %h want 00", score_bcd);
        end
        frame(1, 0, 0, 4'd0, 0, 0);
        check_ball("wall_l", 180, 240);
        frame(0, 0, 1, 4'd0, 0, 0);
        check_ball("top", 185, 241);
        frame(0, 0, 0, 4'b1000, 0, 0);
        check_ball("bumper_grav", 180, 241);
        n_cmp++;
        if (score_bcd !== 8'h01) begin
            n_bad++; $display("FAIL bumper_score: got %h want 01", score_bcd);
        end
    endtask

    task automatic test_kick;
        do_reset();
        pulse_start();
        pulse_start();
        start_solkol = 1'b0;
        repeat (3) @(negedge clk);
        frame(0, 0, 0, 4'd0, 0, 1);
        check_ball("no_kick_angle0", 185, 241);
        frame(0, 0, 0, 4'd0, 1, 0);
        check_ball("kick_left", 190, 234);
        n_cmp++;
        if (doga_sol !== 6'd8 || doga_sag !== 6'd0) begin
            n_bad++;
            $display("FAIL kick_angles: sol=%0d sag=%0d want 8 0", doga_sol, doga_sag);
        end
        start_solkol = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flipper;
        int exp_a;
        do_reset();
        pulse_start();
        pulse_start();
        start_solkol = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            frame(0, 0, 0, 4'd0, 0, 0);
            exp_a = (4 * i > 40) ? 40 : 4 * i;
            n_cmp++;
            if (doga_sol !== 6'(exp_a)) begin
                n_bad++; $display("FAIL flip_up_%0d: got %0d want %0d", i, doga_sol, exp_a);
            end
        end
        start_solkol = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            frame(0, 0, 0, 4'd0, 0, 0);
            exp_a = (40 - 4 * i < 0) ? 0 : 40 - 4 * i;
            n_cmp++;
            if (doga_sol !== 6'(exp_a)) begin
                n_bad++; $display("FAIL flip_dn_%0d: got %0d want %0d", i, doga_sol, exp_a);
            end
        end
        n_cmp++;
        if (doga_sag !== 6'd0) begin
            n_bad++; $display("FAIL flip_sag_idle: got %0d want 0", doga_sag);
        end
    endtask

    task automatic test_timer;
        int k;
        do_reset();
        pulse_start();
        @(negedge clk) startbutton = 1'b1;
        k = 0;
        while (state !== 3'd2 && k < 10) begin
            @(negedge clk);
            k++;
        end
        startbutton = 1'b0;
        n_cmp++;
        if (state !== 3'd2) begin
            n_bad++; $display("FAIL timer_enter: got state %0d want 2", state);
        end
        repeat (149) @(negedge clk);
        n_cmp++;
        if (time_bcd !== 8'h02) begin
            n_bad++; $display("FAIL timer_149: got %h want 02", time_bcd);
        end
        @(negedge clk);
        n_cmp++;
        if (time_bcd !== 8'h03) begin
            n_bad++; $display("FAIL timer_150: got %h want 03", time_bcd);
        end
    endtask

    task automatic test_score;
        int n;
        logic [7:0] exp_s;
        do_reset();
        pulse_start();
        pulse_start();
        for (int i = 1; i <= 100; i++) begin
            frame(0, 0, 0, (i % 2) ? 4'b0110 : 4'b1111, 0, 0);
            n = (i > 99) ? 99 : i;
            exp_s = 8'(((n / 10) << 4) | (n % 10));
            n_cmp++;
            if (score_bcd !== exp_s) begin
                n_bad++; $display("FAIL score_%0d: got %h want %h", i, score_bcd, exp_s);
            end
        end
    endtask

    task automatic test_lives;
        int n;
        do_reset();
        pulse_start();
        pulse_start();
        for (int life = 0; life < 3; life++) begin
            n = 0;
            while (state !== 3'd3 && n < 100) begin
                frame(0, 0, 0, 4'd0, 0, 0);
                n++;
            end
            n_cmp++;
            if (n != 54 || lives !== 2'(2 - life)) begin
                n_bad++;
                $display("FAIL lost_%0d: frames=%0d lives=%0d want 54 %0d",
                         life, n, lives, 2 - life);
            end
            repeat (59) frame(0, 0, 0, 4'd0, 0, 0);
            check_ball($sformatf("lost_frozen_%0d", life), 450, 503);
            n_cmp++;
            if (state !== 3'd3) begin
                n_bad++; $display("FAIL lost_hold_%0d: got %0d want 3", life, state);
            end
            frame(0, 0, 0, 4'd0, 0, 0);
            n_cmp++;
            if (state !== ((life < 2) ? 3'd1 : 3'd4)) begin
                n_bad++;
                $display("FAIL lost_exit_%0d: got %0d want %0d",
                         life, state, (life < 2) ? 1 : 4);
            end
            if (life < 2) pulse_start();
        end
        pulse_start();
        n_cmp++;
        if (state !== 3'd0 || lives !== 2'd3) begin
            n_bad++;
            $display("FAIL over_to_idle: st=%0d lives=%0d want 0 3", state, lives);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        pulse_start();
        pulse_start();
        frame(0, 0, 0, 4'b0001, 0, 0);
        frame(0, 0, 0, 4'd0, 0, 0);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state !== 3'd0 || lives !== 2'd3 || score_bcd !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: st=%0d lives=%0d sc=%h want 0 3 00",
                     state, lives, score_bcd);
        end
        check_ball("mid_reset_ball", 180, 242);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        test_reset();
        test_motion();
        test_priority();
        test_kick();
        test_flipper();
        test_timer();
        test_score();
        test_lives();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
